// File: rtl/nibbler_pkg.sv
// Shared nibbler constants: opcode map and sequencing phase encodings.
// The decoder, ALU and branch unit all import this package.
package nibbler_pkg;

  localparam logic [3:0] OP_JC     = 4'h0;
  localparam logic [3:0] OP_JNC    = 4'h1;
  localparam logic [3:0] OP_JZ     = 4'h2;
  localparam logic [3:0] OP_JNZ    = 4'h3;
  localparam logic [3:0] OP_JMP    = 4'h4;
  // The ALU class occupies 0x8 through 0xF, which is the top half of the opcode map.
  localparam logic [3:0] OP_ALU_LO = 4'h8;

  typedef enum logic {
    PH_FETCH   = 1'b0,
    PH_EXECUTE = 1'b1
  } phase_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU_LO);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: a purely combinational decision for the latched opcode
// against the live carry and zero flags.
module cond_eval
  import nibbler_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       C,
  input  logic       Zeta,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (opcode)
      OP_JC:   take = C;
      OP_JNC:  take = ~C;
      OP_JZ:   take = Zeta;
      OP_JNZ:  take = ~Zeta;
      OP_JMP:  take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Fetch/execute sequencer with program counter, instruction latch and flag-driven branches.
//   state      | meaning
//   PH_FETCH   | latch opcode, advance pc by one (wraps)
//   PH_EXECUTE | resolve branch on live flags, raise flags_we for ALU-class ops
module flag_branch_unit
  import nibbler_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enabled,
  input  logic            C,
  input  logic            Zeta,
  input  logic [3:0]      opcode,
  input  logic [PC_W-1:0] jump_addr,
  output logic [PC_W-1:0] pc,
  output logic            phase,
  output logic            taken,
  output logic            flags_we
);

  phase_e          state_q, state_d;
  logic [3:0]      ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            take;

  // Flags are used directly: a flags write issued this cycle lands after the decision.
  cond_eval u_cond_eval (
    .opcode (ir_q),
    .C      (C),
    .Zeta   (Zeta),
    .take   (take)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    taken_d  = 1'b0;
    flags_we = 1'b0;
    if (enabled) begin
      case (state_q)
        PH_FETCH: begin
          ir_d    = opcode;
          pc_d    = pc_q + PC_W'(1);
          state_d = PH_EXECUTE;
        end
        PH_EXECUTE: begin
          if (take) pc_d = jump_addr;
          taken_d  = take;
          flags_we = is_alu_op(ir_q) && !rst;
          state_d  = PH_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_FETCH;
      ir_q    <= 4'h0;
      pc_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end

  assign pc    = pc_q;
  assign phase = state_q;
  assign taken = taken_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed literal scenarios followed by random traffic,
// all checked every cycle against an instruction-level reference model.
module tb_flag_branch_unit;

  localparam int PC_W = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enabled = 1'b0;
  logic            C = 1'b0;
  logic            Zeta = 1'b0;
  logic [3:0]      opcode = 4'h0;
  logic [PC_W-1:0] jump_addr = '0;
  logic [PC_W-1:0] pc;
  logic            phase;
  logic            taken;
  logic            flags_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flag_branch_unit #(.PC_W(PC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enabled   (enabled),
    .C         (C),
    .Zeta      (Zeta),
    .opcode    (opcode),
    .jump_addr (jump_addr),
    .pc        (pc),
    .phase     (phase),
    .taken     (taken),
    .flags_we  (flags_we)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one instruction is a fetch step followed by an execute step.
  int  m_pc;
  int  m_ir;
  bit  m_exec;
  bit  m_taken;
  bit  m_valid = 0;

  function automatic bit branch_rule(input int op, input bit c, input bit z);
    if (op == 0) return c;
    if (op == 1) return !c;
    if (op == 2) return z;
    if (op == 3) return !z;
    if (op == 4) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_ir = 0; m_exec = 0; m_taken = 0; m_valid = 1;
    end else if (!enabled) begin
      m_taken = 0;
    end else if (!m_exec) begin
      m_ir    = int'(opcode);
      m_pc    = (m_pc + 1) % (1 << PC_W);
      m_exec  = 1;
      m_taken = 0;
    end else begin
      m_taken = branch_rule(m_ir, C, Zeta);
      if (m_taken) m_pc = int'(jump_addr);
      m_exec = 0;
    end
  end

  always @(negedge clk) begin
    #3;
    if (m_valid) begin
      check("model_pc", 32'(pc), 32'(m_pc));
      check("model_phase", 32'(phase), 32'(m_exec));
      check("model_taken", 32'(taken), 32'(m_taken));
      check("model_flags_we", 32'(flags_we),
            32'(!rst && enabled && m_exec && (m_ir >= 8)));
    end
  end

  logic last_fwe;

  task automatic cyc(input bit r, input bit en, input logic [3:0] op,
                     input bit c, input bit z, input logic [PC_W-1:0] ja);
    rst = r; enabled = en; opcode = op; C = c; Zeta = z; jump_addr = ja;
    #1 last_fwe = flags_we;
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] op, input bit c, input bit z,
                       input logic [PC_W-1:0] ja, input logic [PC_W-1:0] f_pc,
                       input logic [PC_W-1:0] e_pc, input bit t);
    cyc(0, 1, op, c, z, ja);
    check("fetch_pc", 32'(pc), 32'(f_pc));
    check("fetch_phase", 32'(phase), 32'(1));
    cyc(0, 1, op, c, z, ja);
    check("exec_pc", 32'(pc), 32'(e_pc));
    check("exec_phase", 32'(phase), 32'(0));
    check("exec_taken", 32'(taken), 32'(t));
  endtask

  initial begin
    // Reset, then two ALU-class instructions.
    cyc(1, 0, 4'h0, 0, 0, 12'h000);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_taken", 32'(taken), 32'h0);
    cyc(0, 1, 4'h9, 0, 0, 12'h000);
    check("alu_f1_fwe", 32'(last_fwe), 32'h0);
    check("alu_f1_pc", 32'(pc), 32'h1);
    cyc(0, 1, 4'h9, 0, 0, 12'h000);
    check("alu_e1_fwe", 32'(last_fwe), 32'h1);
    check("alu_e1_pc", 32'(pc), 32'h1);
    check("alu_e1_taken", 32'(taken), 32'h0);
    cyc(0, 1, 4'h9, 0, 0, 12'h000);
    check("alu_f2_pc", 32'(pc), 32'h2);
    cyc(0, 1, 4'h9, 0, 0, 12'h000);
    check("alu_e2_fwe", 32'(last_fwe), 32'h1);
    check("alu_e2_pc", 32'(pc), 32'h2);

    // JC with carry set and clear, starting from pc 0x010.
    instr(4'h4, 0, 0, 12'h010, 12'h003, 12'h010, 1);
    instr(4'h0, 1, 0, 12'h3A5, 12'h011, 12'h3A5, 1);
    instr(4'h4, 0, 0, 12'h010, 12'h3A6, 12'h010, 1);
    instr(4'h0, 0, 0, 12'h3A5, 12'h011, 12'h011, 0);

    // JZ / JNZ on both zero-flag values, then JMP with flags clear.
    instr(4'h2, 0, 1, 12'h100, 12'h012, 12'h100, 1);
    instr(4'h2, 0, 0, 12'h200, 12'h101, 12'h101, 0);
    instr(4'h3, 0, 1, 12'h200, 12'h102, 12'h102, 0);
    instr(4'h3, 0, 0, 12'h300, 12'h103, 12'h300, 1);
    instr(4'h4, 0, 0, 12'h055, 12'h301, 12'h055, 1);

    // Wrap from 0xFFF on fetch, and a jump to the current pc (tight loop).
    instr(4'h4, 0, 0, 12'hFFF, 12'h056, 12'hFFF, 1);
    instr(4'hA, 0, 0, 12'h123, 12'h000, 12'h000, 0);
    instr(4'h4, 0, 0, 12'h001, 12'h001, 12'h001, 1);

    // Stall three cycles in the execute step of a JMP.
    cyc(0, 1, 4'h4, 0, 0, 12'h0AB);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 4'h4, 0, 0, 12'h0AB);
      check("stall_pc", 32'(pc), 32'h002);
      check("stall_phase", 32'(phase), 32'h1);
      check("stall_taken", 32'(taken), 32'h0);
      check("stall_fwe", 32'(last_fwe), 32'h0);
    end
    cyc(0, 1, 4'h4, 0, 0, 12'h0AB);
    check("resume_pc", 32'(pc), 32'h0AB);
    check("resume_taken", 32'(taken), 32'h1);

    // Reset during the execute step of JMP 0x200, and during an ALU op.
    cyc(0, 1, 4'h4, 0, 0, 12'h200);
    cyc(1, 1, 4'h4, 0, 0, 12'h200);
    check("rstx_pc", 32'(pc), 32'h0);
    check("rstx_phase", 32'(phase), 32'h0);
    check("rstx_taken", 32'(taken), 32'h0);
    cyc(0, 1, 4'hA, 0, 0, 12'h000);
    cyc(1, 1, 4'hA, 0, 0, 12'h000);
    check("rst_fwe", 32'(last_fwe), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(3) != 0),
          4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
          PC_W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
